// File: rtl/recip_pkg.sv
// Shared types and default widths for the reciprocal frequency counter stages.
package recip_pkg;

  localparam int unsigned SyncStagesDefault = 2;
  localparam int unsigned EdgeWDefault      = 16;
  localparam int unsigned TimeoutWDefault   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StGate,
    StDone
  } gate_state_e;

endpackage

// File: rtl/recip_gate_gen_if.sv
// Control/status bundle between the measurement controller and the gate generator.
interface recip_gate_gen_if
  import recip_pkg::*;
#(
  parameter int unsigned EDGE_W    = EdgeWDefault,
  parameter int unsigned TIMEOUT_W = TimeoutWDefault
);

  logic                 start;
  logic [EDGE_W-1:0]    gate_edges;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic                 sample_gate;
  logic                 busy;
  logic                 gate_done;
  logic [EDGE_W-1:0]    event_count;
  logic                 timeout_err;

  modport master (
    output start, gate_edges, timeout_cycles,
    input  sample_gate, busy, gate_done, event_count, timeout_err
  );

  modport slave (
    input  start, gate_edges, timeout_cycles,
    output sample_gate, busy, gate_done, event_count, timeout_err
  );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/recip_gate_gen.sv
// Opens and closes sample_gate on synchronised rising edges of sig_in, spanning a programmed
// number of signal periods, with an optional ref_clk-cycle timeout.
module recip_gate_gen
  import recip_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDefault,
  parameter int unsigned EDGE_W      = EdgeWDefault,
  parameter int unsigned TIMEOUT_W   = TimeoutWDefault
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             sig_in,
  recip_gate_gen_if.slave  gif
);

  gate_state_e          state_q, state_d;
  logic [EDGE_W-1:0]    n_q, n_d;
  logic [EDGE_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [EDGE_W-1:0]    event_count_q, event_count_d;
  logic [TIMEOUT_W-1:0] t_q, t_d;
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
  logic                 gate_q, gate_d;
  logic                 terr_q, terr_d;

  logic                 rise;
  logic [EDGE_W-1:0]    edge_next;
  logic [TIMEOUT_W-1:0] to_cnt_inc;
  logic                 timeout_hit;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i  (ref_clk),
    .rst_i  (reset),
    .async_i(sig_in),
    .rise_o (rise)
  );

  assign edge_next   = edge_cnt_q + EDGE_W'(1);
  assign to_cnt_inc  = (&to_cnt_q) ? to_cnt_q : to_cnt_q + TIMEOUT_W'(1);
  assign timeout_hit = (t_q != '0) && (to_cnt_q == t_q - TIMEOUT_W'(1));

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    edge_cnt_d    = edge_cnt_q;
    event_count_d = event_count_q;
    t_d           = t_q;
    to_cnt_d      = to_cnt_q;
    gate_d        = gate_q;
    terr_d        = terr_q;

    unique case (state_q)
      StIdle: begin
        if (gif.start) begin
          n_d      = (gif.gate_edges == '0) ? EDGE_W'(1) : gif.gate_edges;
          t_d      = gif.timeout_cycles;
          to_cnt_d = '0;
          terr_d   = 1'b0;
          state_d  = StArm;
        end
      end
      StArm: begin
        to_cnt_d = to_cnt_inc;
        if (timeout_hit) begin
          gate_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = StIdle;
        end else if (rise) begin
          // The opening edge only aligns the gate; it is not counted as a period.
          gate_d     = 1'b1;
          edge_cnt_d = '0;
          state_d    = StGate;
        end
      end
      StGate: begin
        to_cnt_d = to_cnt_inc;
        // A closing edge coinciding with the timeout still completes the measurement.
        if (rise && (edge_next == n_q)) begin
          gate_d        = 1'b0;
          event_count_d = n_q;
          state_d       = StDone;
        end else if (timeout_hit) begin
          gate_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = StIdle;
        end else if (rise) begin
          edge_cnt_d = edge_next;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q       <= StIdle;
      n_q           <= '0;
      edge_cnt_q    <= '0;
      event_count_q <= '0;
      t_q           <= '0;
      to_cnt_q      <= '0;
      gate_q        <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      edge_cnt_q    <= edge_cnt_d;
      event_count_q <= event_count_d;
      t_q           <= t_d;
      to_cnt_q      <= to_cnt_d;
      gate_q        <= gate_d;
      terr_q        <= terr_d;
    end
  end

  assign gif.sample_gate = gate_q;
  assign gif.busy        = (state_q == StArm) || (state_q == StGate);
  assign gif.gate_done   = (state_q == StDone);
  assign gif.event_count = event_count_q;
  assign gif.timeout_err = terr_q;

endmodule
